// File: rtl/led_anim_pkg.sv
// ---------------------------------------------------------------------------
// led_anim_pkg
// Shared types and constants for the LED animation sequencer.
//   anim_mode_e  : play mode as presented on the mode input
//   anim_state_e : sequencer control states
//   LED_OFF      : all-ones LED word (active-low, so every LED dark); slice
//                  it to the LED width where it is used
// ---------------------------------------------------------------------------
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSV      = 2'd3
    } anim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } anim_state_e;

    localparam logic [63:0] LED_OFF = {64{1'b1}};

endpackage

// File: rtl/led_frame_timer.sv
// ---------------------------------------------------------------------------
// led_frame_timer
// Frame-rate divider. Counts enabled clock cycles and flags the cycle where
// the count equals div; the counter wraps to zero on that cycle when enabled.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return of the count to zero (has priority)
//   enable     : count this cycle; low holds the count (used for pause)
//   div        : terminal count (cycles per frame minus 1)
//   tick       : count == div (ungated; the caller qualifies it with enable)
// ---------------------------------------------------------------------------
module led_frame_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;

    assign tick = (cnt_r == div);

    // Divider count register: clear wins, otherwise count or wrap when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led_anim_seq.sv
// ---------------------------------------------------------------------------
// led_anim_seq
// LED animation sequencer: steps a frame index through an external pattern
// ROM at a programmable frame rate (loop / one-shot / ping-pong), with pause
// and stop, and registers the returned active-low pattern onto the LEDs.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, stop       : command pulses (stop > start > pause)
//   pause             : level, freezes the frame timer while high
//   mode, div,        : play configuration, latched on start
//   last_frame
//   frame_o / pat_i   : frame index to the ROM / its combinational pattern
//   led_o             : registered active-low LED drive
//   busy, done        : running indicator / one-cycle one-shot completion
//   bright (LED_DIM_EN only) : PWM brightness, 0 = dark .. 15 = lit 15/16
// Build option: define LED_DIM_EN to add the bright input and PWM dimming.
// ---------------------------------------------------------------------------
module led_anim_seq
    import led_anim_pkg::*;
#(
    parameter int LED_W   = 7,
    parameter int FRAME_W = 7,
    parameter int DIV_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   div,
    input  logic [FRAME_W-1:0] last_frame,
    output logic [FRAME_W-1:0] frame_o,
    input  logic [LED_W-1:0]   pat_i,
`ifdef LED_DIM_EN
    input  logic [3:0]         bright,
`endif
    output logic [LED_W-1:0]   led_o,
    output logic               busy,
    output logic               done
);

    localparam logic [LED_W-1:0]   LED_OFF_W = LED_OFF[LED_W-1:0];
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    anim_state_e        state_r, state_s;
    anim_mode_e         mode_r;
    logic [DIV_W-1:0]   div_r;
    logic [FRAME_W-1:0] last_r;
    logic [FRAME_W-1:0] frame_r, frame_s;
    logic               dir_r, dir_s;      // 0 = counting up, 1 = counting down
    logic [LED_W-1:0]   led_r;
    logic               busy_r, done_r;
    logic               done_s, latch_s, clear_s, enable_s, tick_s;

    led_frame_timer #(.DIV_W(DIV_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear_s),
        .enable (enable_s),
        .div    (div_r),
        .tick   (tick_s)
    );

    // Next-state, frame advance and direction logic.
    always_comb begin
        state_s  = state_r;
        frame_s  = frame_r;
        dir_s    = dir_r;
        done_s   = 1'b0;
        latch_s  = 1'b0;
        clear_s  = 1'b0;
        enable_s = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            frame_s = '0;
            dir_s   = 1'b0;
            clear_s = 1'b1;
        end else if (start) begin
            state_s = ST_RUN;
            frame_s = '0;
            dir_s   = 1'b0;
            clear_s = 1'b1;
            latch_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_s = ST_PAUSED;
                    end else begin
                        // Releasing pause counts in the same cycle, so the
                        // remaining frame time is preserved exactly.
                        state_s  = ST_RUN;
                        enable_s = 1'b1;
                        if (tick_s) begin
                            case (mode_r)
                                MODE_ONESHOT: begin
                                    if (frame_r == last_r) begin
                                        state_s = ST_DONE;
                                        done_s  = 1'b1;
                                    end else begin
                                        frame_s = frame_r + 1'b1;
                                    end
                                end
                                MODE_PINGPONG: begin
                                    if (last_r == '0) begin
                                        frame_s = '0;
                                    end else if (!dir_r) begin
                                        if (frame_r == last_r) begin
                                            dir_s   = 1'b1;
                                            frame_s = last_r - 1'b1;
                                        end else begin
                                            frame_s = frame_r + 1'b1;
                                        end
                                    end else begin
                                        if (frame_r == '0) begin
                                            dir_s   = 1'b0;
                                            frame_s = FRAME_ONE;
                                        end else begin
                                            frame_s = frame_r - 1'b1;
                                        end
                                    end
                                end
                                default: begin
                                    // Loop; the reserved encoding plays as loop too.
                                    if (frame_r == last_r) begin
                                        frame_s = '0;
                                    end else begin
                                        frame_s = frame_r + 1'b1;
                                    end
                                end
                            endcase
                        end else begin
                            frame_s = frame_r;
                        end
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end
    end

    // Control state, frame index, latched configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            frame_r <= '0;
            dir_r   <= 1'b0;
            mode_r  <= MODE_LOOP;
            div_r   <= '0;
            last_r  <= '0;
            led_r   <= LED_OFF_W;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            frame_r <= frame_s;
            dir_r   <= dir_s;
            if (latch_s) begin
                mode_r <= anim_mode_e'(mode);
                div_r  <= div;
                last_r <= last_frame;
            end
            // Keyed on the next state so that stop darkens the LEDs on the
            // very edge that enters IDLE.
            led_r  <= (state_s == ST_IDLE) ? LED_OFF_W : pat_i;
            busy_r <= (state_s == ST_RUN) || (state_s == ST_PAUSED);
            done_r <= done_s;
        end
    end

    assign frame_o = frame_r;
    assign busy    = busy_r;
    assign done    = done_r;

`ifdef LED_DIM_EN
    logic [3:0] pwm_r;

    // Free-running PWM phase counter for dimming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 4'd0;
        end else begin
            pwm_r <= pwm_r + 4'd1;
        end
    end

    // A lit (low) bit stays low only while the PWM phase is below bright.
    assign led_o = led_r | {LED_W{~(pwm_r < bright)}};
`else
    assign led_o = led_r;
`endif

endmodule
